// File: rtl/rate_detector.sv
// Recovers the 2-bit speed code of a rate divider from its tick stream by measuring
// tick-to-tick periods, classifying them, and locking after consistent repeats.
//
// state   | meaning
// IDLE    | no reference tick yet (after reset or tick loss)
// MEASURE | counting cycles since the last tick
module rate_detector #(
  parameter int CNT_W    = 28,
  parameter int PERIOD_1 = 25000000,
  parameter int PERIOD_2 = 50000000,
  parameter int PERIOD_3 = 100000000,
  parameter int TOL      = 1024,
  parameter int LOCK_N   = 2,
  parameter int TIMEOUT  = 200000000
) (
  input  logic             ClockIn,
  input  logic             Clear_b,
  input  logic             TickIn,
  output logic [1:0]       Speed,
  output logic             Valid,
  output logic [CNT_W-1:0] Period,
  output logic             Sample,
  output logic             Lost
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W:0]   P1_X      = (CNT_W+1)'(PERIOD_1);
  localparam logic [CNT_W:0]   P2_X      = (CNT_W+1)'(PERIOD_2);
  localparam logic [CNT_W:0]   P3_X      = (CNT_W+1)'(PERIOD_3);
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [2:0]       LOCK_C    = 3'(LOCK_N);
  localparam logic [2:0]       MATCH_ONE = 3'd1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [2:0]       match, match_nxt, match_run;
  logic [1:0]       prev_code, prev_code_nxt;
  logic [1:0]       speed_nxt;
  logic             valid_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             sample_nxt;
  logic             lost_nxt;
  logic [1:0]       code;
  logic             code_ok;

  // |c - p| <= TOL, done one bit wider so the difference never wraps
  function automatic logic within_tol(input logic [CNT_W-1:0] c, input logic [CNT_W:0] p);
    logic [CNT_W:0] diff;
    logic [CNT_W:0] mag;
    diff = {1'b0, c} - p;
    mag  = diff[CNT_W] ? -diff : diff;
    return (mag <= TOL_X);
  endfunction

  always_comb begin
    code    = 2'b00;
    code_ok = 1'b1;
    if (cnt == CNT_ONE)            code = 2'b00;
    else if (within_tol(cnt, P1_X)) code = 2'b01;
    else if (within_tol(cnt, P2_X)) code = 2'b10;
    else if (within_tol(cnt, P3_X)) code = 2'b11;
    else                           code_ok = 1'b0;
  end

  always_comb begin
    cnt_inc   = cnt + CNT_ONE;
    match_run = MATCH_ONE;
    if ((match != 3'd0) && (code == prev_code))
      match_run = (match >= LOCK_C) ? LOCK_C : match + MATCH_ONE;
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    match_nxt     = match;
    prev_code_nxt = prev_code;
    speed_nxt     = Speed;
    valid_nxt     = Valid;
    period_nxt    = Period;
    sample_nxt    = 1'b0;
    lost_nxt      = Lost;
    case (state)
      IDLE: begin
        if (TickIn) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
          lost_nxt  = 1'b0;
        end
      end
      MEASURE: begin
        if (TickIn) begin
          // a tick coinciding with the timeout count still counts as a measurement
          period_nxt = cnt;
          sample_nxt = 1'b1;
          cnt_nxt    = CNT_ONE;
          lost_nxt   = 1'b0;
          if (code_ok) begin
            match_nxt     = match_run;
            prev_code_nxt = code;
            valid_nxt     = (match_run == LOCK_C);
            if (match_run == LOCK_C) speed_nxt = code;
          end else begin
            match_nxt = 3'd0;
            valid_nxt = 1'b0;
          end
        end else if (cnt_inc == TIMEOUT_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          match_nxt = 3'd0;
          valid_nxt = 1'b0;
          lost_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ClockIn or negedge Clear_b) begin
    if (!Clear_b) begin
      state     <= IDLE;
      cnt       <= '0;
      match     <= 3'd0;
      prev_code <= 2'b00;
      Speed     <= 2'b00;
      Valid     <= 1'b0;
      Period    <= '0;
      Sample    <= 1'b0;
      Lost      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      match     <= match_nxt;
      prev_code <= prev_code_nxt;
      Speed     <= speed_nxt;
      Valid     <= valid_nxt;
      Period    <= period_nxt;
      Sample    <= sample_nxt;
      Lost      <= lost_nxt;
    end
  end

endmodule
